// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: default widths and the registered control-field bundle of the operand stage.
package alu_operand_stage_pkg;

  localparam int OPERAND_WIDTH_DEF  = 16;
  localparam int REG_ID_W_DEF       = 3;
  localparam int NUM_OPERATIONS_DEF = 4;

  typedef struct packed {
    logic [NUM_OPERATIONS_DEF-1:0] oper;
    logic                          inv_a;
    logic                          inv_b;
    logic                          cin;
    logic                          sign;
    logic [REG_ID_W_DEF-1:0]       rd;
    logic                          wr;
    logic                          use_imm;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// fwd_mux: per-operand forwarding select, EX/MEM result beats MEM/WB result beats the held operand.
module fwd_mux #(
  parameter int W  = 16,
  parameter int RW = 3
) (
  input  logic          en,
  input  logic [RW-1:0] src,
  input  logic [W-1:0]  held,
  input  logic          exmem_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_data,
  input  logic          memwb_wr,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_data,
  output logic [W-1:0]  value
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = en & exmem_wr & (exmem_rd == src);
  assign wb_hit = en & memwb_wr & (memwb_rd == src);
  assign value  = ex_hit ? exmem_data : wb_hit ? memwb_data : held;

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode->ALU pipeline register; ALU_OPERAND_FWD_EN compiles in EX/MEM and MEM/WB forwarding.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int OPERAND_WIDTH  = OPERAND_WIDTH_DEF,
  parameter int REG_ID_W       = REG_ID_W_DEF,
  parameter int NUM_OPERATIONS = NUM_OPERATIONS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [OPERAND_WIDTH-1:0]  id_rs_data,
  input  logic [OPERAND_WIDTH-1:0]  id_rt_data,
  input  logic [OPERAND_WIDTH-1:0]  id_imm,
  input  logic [REG_ID_W-1:0]       id_rs,
  input  logic [REG_ID_W-1:0]       id_rt,
  input  logic [REG_ID_W-1:0]       id_rd,
  input  logic                      id_use_imm,
  input  logic                      id_wr,
  input  logic [NUM_OPERATIONS-1:0] id_oper,
  input  logic                      id_inv_a,
  input  logic                      id_inv_b,
  input  logic                      id_cin,
  input  logic                      id_sign,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      exmem_wr,
  input  logic [REG_ID_W-1:0]       exmem_rd,
  input  logic [OPERAND_WIDTH-1:0]  exmem_data,
  input  logic                      memwb_wr,
  input  logic [REG_ID_W-1:0]       memwb_rd,
  input  logic [OPERAND_WIDTH-1:0]  memwb_data,
  output logic                      ex_valid,
  output logic [OPERAND_WIDTH-1:0]  InA,
  output logic [OPERAND_WIDTH-1:0]  InB,
  output logic                      Cin,
  output logic [NUM_OPERATIONS-1:0] Oper,
  output logic                      invA,
  output logic                      invB,
  output logic                      sign,
  output logic [REG_ID_W-1:0]       ex_rd,
  output logic                      ex_wr
);

  logic                     valid_q;
  logic [OPERAND_WIDTH-1:0] a_q;
  logic [OPERAND_WIDTH-1:0] b_q;
  logic [REG_ID_W-1:0]      rs_q;
  logic [REG_ID_W-1:0]      rt_q;
  ctrl_t                    ctrl_q;
  logic [OPERAND_WIDTH-1:0] fwd_a;
  logic [OPERAND_WIDTH-1:0] fwd_b;

`ifdef ALU_OPERAND_FWD_EN
  fwd_mux #(.W(OPERAND_WIDTH), .RW(REG_ID_W)) u_fwd_a (
    .en(valid_q), .src(rs_q), .held(a_q),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .value(fwd_a)
  );
  // an immediate in B never takes a forwarded register value
  fwd_mux #(.W(OPERAND_WIDTH), .RW(REG_ID_W)) u_fwd_b (
    .en(valid_q & ~ctrl_q.use_imm), .src(rt_q), .held(b_q),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .value(fwd_b)
  );
`else
  logic unused_fwd;
  assign fwd_a      = a_q;
  assign fwd_b      = b_q;
  assign unused_fwd = ^{exmem_wr, exmem_rd, exmem_data, memwb_wr, memwb_rd, memwb_data,
                        rs_q, rt_q, ctrl_q.use_imm};
`endif

  // a stalled operand absorbs its forwarded value so it survives the producer retiring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else if (flush) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else if (stall) begin
      a_q <= fwd_a;
      b_q <= fwd_b;
    end else begin
      valid_q        <= id_valid;
      a_q            <= id_rs_data;
      b_q            <= id_use_imm ? id_imm : id_rt_data;
      rs_q           <= id_rs;
      rt_q           <= id_rt;
      ctrl_q.oper    <= id_oper;
      ctrl_q.inv_a   <= id_inv_a;
      ctrl_q.inv_b   <= id_inv_b;
      ctrl_q.cin     <= id_cin;
      ctrl_q.sign    <= id_sign;
      ctrl_q.rd      <= id_rd;
      ctrl_q.wr      <= id_wr;
      ctrl_q.use_imm <= id_use_imm;
    end
  end

  assign ex_valid = valid_q;
  assign InA      = fwd_a;
  assign InB      = fwd_b;
  assign Cin      = ctrl_q.cin;
  assign Oper     = ctrl_q.oper;
  assign invA     = ctrl_q.inv_a;
  assign invB     = ctrl_q.inv_b;
  assign sign     = ctrl_q.sign;
  assign ex_rd    = ctrl_q.rd;
  assign ex_wr    = ctrl_q.wr & valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors plus an instruction-level model checked every cycle; honours ALU_OPERAND_FWD_EN.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_imm, id_wr, id_inv_a, id_inv_b, id_cin, id_sign;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_oper;
  logic        stall, flush;
  logic        exmem_wr, memwb_wr;
  logic [2:0]  exmem_rd, memwb_rd;
  logic [15:0] exmem_data, memwb_data;
  logic        ex_valid, Cin, invA, invB, sign, ex_wr;
  logic [15:0] InA, InB;
  logic [3:0]  Oper;
  logic [2:0]  ex_rd;

  int vectors = 0;
  int miscompares = 0;

  alu_operand_stage #(.OPERAND_WIDTH(16), .REG_ID_W(3), .NUM_OPERATIONS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_use_imm(id_use_imm), .id_wr(id_wr),
    .id_oper(id_oper), .id_inv_a(id_inv_a), .id_inv_b(id_inv_b), .id_cin(id_cin), .id_sign(id_sign),
    .stall(stall), .flush(flush),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .InA(InA), .InB(InB), .Cin(Cin), .Oper(Oper),
    .invA(invA), .invB(invB), .sign(sign), .ex_rd(ex_rd), .ex_wr(ex_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] a, b;
    logic [2:0]  rs, rt, rd;
    logic        use_imm, wr, inv_a, inv_b, cin, sign;
    logic [3:0]  oper;
  } instr_t;

  instr_t m;

  function automatic logic [15:0] fwd(input logic [2:0] id, input logic [15:0] held, input logic v);
    if (FWD && v && exmem_wr && exmem_rd == id) return exmem_data;
    if (FWD && v && memwb_wr && memwb_rd == id) return memwb_data;
    return held;
  endfunction

  function automatic logic [15:0] exp_a();
    return fwd(m.rs, m.a, m.valid);
  endfunction

  function automatic logic [15:0] exp_b();
    return m.use_imm ? m.b : fwd(m.rt, m.b, m.valid);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] fa, fb;
    if (!rst_n) begin
      m = '{default: '0};
    end else begin
      fa = exp_a();
      fb = exp_b();
      if (flush) m = '{default: '0};
      else if (stall) begin
        m.a = fa;
        m.b = fb;
      end else begin
        m.valid = id_valid;   m.a = id_rs_data;  m.b = id_use_imm ? id_imm : id_rt_data;
        m.rs = id_rs;         m.rt = id_rt;      m.rd = id_rd;
        m.use_imm = id_use_imm; m.wr = id_wr;    m.oper = id_oper;
        m.inv_a = id_inv_a;   m.inv_b = id_inv_b; m.cin = id_cin; m.sign = id_sign;
      end
    end
  end

  always @(negedge clk) begin
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    chk("InA", 32'(InA), 32'(exp_a()));
    chk("InB", 32'(InB), 32'(exp_b()));
    chk("Oper", 32'(Oper), 32'(m.oper));
    chk("ctl", 32'({Cin, invA, invB, sign}), 32'({m.cin, m.inv_a, m.inv_b, m.sign}));
    chk("ex_rd", 32'(ex_rd), 32'(m.rd));
    chk("ex_wr", 32'(ex_wr), 32'(m.wr & m.valid));
  end

  task automatic idle();
    id_valid = 0; id_use_imm = 0; id_wr = 0; id_inv_a = 0; id_inv_b = 0; id_cin = 0; id_sign = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_oper = 0;
    stall = 0; flush = 0;
    exmem_wr = 0; exmem_rd = 0; exmem_data = 0; memwb_wr = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) tick();
    chk("reset_valid", 32'(ex_valid), 32'd0);
    rst_n = 1;
    id_valid = 1; id_rs_data = 16'h1234; id_imm = 16'h0005; id_use_imm = 1; id_oper = 4'b0100;
    id_rt_data = 16'h9999;
    tick();
    #1;
    chk("load_InA", 32'(InA), 32'h1234);
    chk("load_InB", 32'(InB), 32'h0005);
    chk("load_Oper", 32'(Oper), 32'h4);
    chk("load_valid", 32'(ex_valid), 32'd1);
    id_rs = 2; id_rs_data = 16'h1111; id_rt = 3; id_rt_data = 16'h2222; id_use_imm = 0;
    id_wr = 1; id_rd = 5; id_oper = 4'd3; id_cin = 1;
    tick();
    stall = 1;
    exmem_wr = 1; exmem_rd = 2; exmem_data = 16'hAAAA;
    memwb_wr = 1; memwb_rd = 2; memwb_data = 16'h5555;
    #1 chk("prio_exmem", 32'(InA), FWD ? 32'hAAAA : 32'h1111);
    exmem_wr = 0;
    #1 chk("prio_memwb", 32'(InA), FWD ? 32'h5555 : 32'h1111);
    tick();
    memwb_rd = 3; memwb_data = 16'h00FF;
    tick();
    memwb_wr = 0;
    #1;
    chk("refresh_InB", 32'(InB), FWD ? 32'h00FF : 32'h2222);
    chk("refresh_InA", 32'(InA), FWD ? 32'h5555 : 32'h1111);
    tick();
    chk("refresh_hold", 32'(InB), FWD ? 32'h00FF : 32'h2222);
    chk("stall_ex_wr", 32'(ex_wr), 32'd1);
    flush = 1; id_valid = 1; id_wr = 1;
    tick();
    #1;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_ex_wr", 32'(ex_wr), 32'd0);
    chk("flush_Oper", 32'(Oper), 32'd0);
    flush = 0; stall = 0;
    exmem_wr = 1; exmem_rd = 0; exmem_data = 16'hDEAD;
    #1 chk("invalid_nofwd", 32'(InA), 32'd0);
    exmem_wr = 0;
    id_use_imm = 1; id_imm = 16'h0007; id_rt = 1; id_rt_data = 16'h3333; id_rs = 4;
    tick();
    exmem_wr = 1; exmem_rd = 1; exmem_data = 16'hBEEF;
    #1 chk("imm_suppress", 32'(InB), 32'h0007);
    rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'd0);
    chk("async_rst_InA", 32'(InA), 32'd0);
    chk("async_rst_InB", 32'(InB), 32'd0);
    chk("async_rst_rd", 32'(ex_rd), 32'd0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 60; i++) begin
      id_valid = 1'($urandom); id_use_imm = 1'($urandom); id_wr = 1'($urandom);
      id_inv_a = 1'($urandom); id_inv_b = 1'($urandom); id_cin = 1'($urandom); id_sign = 1'($urandom);
      id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
      id_rs = 3'($urandom); id_rt = 3'($urandom); id_rd = 3'($urandom); id_oper = 4'($urandom);
      stall = ($urandom_range(0, 2) == 0); flush = ($urandom_range(0, 7) == 0);
      exmem_wr = 1'($urandom); exmem_rd = 3'($urandom); exmem_data = 16'($urandom);
      memwb_wr = 1'($urandom); memwb_rd = 3'($urandom); memwb_data = 16'($urandom);
      tick();
    end
    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter OPERAND_WIDTH, default 16, data width of operands, immediates and forwarded results.
REQ-002 Parameter REG_ID_W, default 3, register-specifier width.
REQ-003 Parameter NUM_OPERATIONS, default 4, width of the ALU operation code.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Decode inputs: id_valid 1; id_rs_data, id_rt_data, id_imm OPERAND_WIDTH; id_rs, id_rt, id_rd REG_ID_W; id_use_imm 1; id_wr 1; id_oper NUM_OPERATIONS; id_inv_a, id_inv_b, id_cin, id_sign 1 each.
REQ-007 Control inputs: stall 1 (hold stage contents); flush 1 (kill stage contents).
REQ-008 Forwarding inputs: exmem_wr 1, exmem_rd REG_ID_W, exmem_data OPERAND_WIDTH; memwb_wr 1, memwb_rd REG_ID_W, memwb_data OPERAND_WIDTH.
REQ-009 Outputs to ALU: ex_valid 1, InA OPERAND_WIDTH, InB OPERAND_WIDTH, Cin 1, Oper NUM_OPERATIONS, invA 1, invB 1, sign 1; to later stages: ex_rd REG_ID_W, ex_wr 1.

Function
REQ-010 The stage SHALL be one pipeline register between decode and the ALU, holding valid, operand A, operand B, rs/rt ids, use_imm, rd, wr and all ALU control fields.
REQ-011 Update priority per rising edge SHALL be: flush, then stall, then load.
REQ-012 Flush SHALL clear ex_valid, ex_wr, Oper, invA, invB, Cin, sign and ex_rd to 0 (bubble); operand fields unspecified but deterministic (cleared to 0).
REQ-013 Stall without flush SHALL hold all fields except operands, which are refreshed per REQ-016.
REQ-014 Load SHALL capture id_* fields; operand B captures id_imm when id_use_imm=1, else id_rt_data.
REQ-015 Forwarding (outputs combinational from registered state): InA = exmem_data if exmem_wr and exmem_rd==held rs; else memwb_data if memwb_wr and memwb_rd==held rs; else held A. InB same against held rt, suppressed when held use_imm=1.
REQ-016 During stall, each held operand SHALL be overwritten with its forwarded value when a forwarding hit exists, so a value is not lost when its producer retires.
REQ-017 EX/MEM SHALL win over MEM/WB when both match the same register.
REQ-018 Forwarding SHALL apply only when ex_valid=1; when ex_valid=0, InA/InB equal held registers.
REQ-019 ex_wr SHALL equal held wr AND ex_valid.
REQ-020 Latency: decode fields appear on outputs one cycle after capture; no combinational path from id_* to any output.
REQ-021 stall and flush together SHALL flush.

Reset
REQ-022 While rst_n=0, every registered field SHALL be 0 immediately (asynchronous); outputs: ex_valid=0, ex_wr=0, InA=0, InB=0, Oper=0, Cin=invA=invB=sign=0, ex_rd=0.
REQ-023 Deassertion SHALL take effect on the first rising clk with rst_n=1; reset mid-stall discards held instruction.

Configuration
REQ-024 Macro ALU_OPERAND_FWD_EN defined: forwarding per REQ-015..REQ-018 compiled in.
REQ-025 Macro ALU_OPERAND_FWD_EN undefined: InA/InB are held registers directly, REQ-016 refresh removed, forwarding inputs unused; all other behaviour identical.

Structure
REQ-026 Shared package SHALL hold default widths (operand 16, reg id 3, oper 4) and the pipeline-stage control-field struct (oper, inv_a, inv_b, cin, sign, rd, wr, use_imm).
REQ-027 One sub-module fwd_mux SHALL implement the per-operand priority select; instantiated twice (A, B).

Verification
REQ-028 Reset: rst_n=0 asynchronously mid-cycle with ex_valid=1 -> all outputs 0 before next edge.
REQ-029 Load: id_valid=1, id_rs_data=0x1234, id_imm=0x0005, id_use_imm=1, id_oper=4'b0100 -> next cycle InA=0x1234, InB=0x0005, Oper=0100, ex_valid=1.
REQ-030 Priority: held rs=2, exmem_wr=1 rd=2 data=0xAAAA, memwb_wr=1 rd=2 data=0x5555 -> InA=0xAAAA; exmem_wr=0 -> InA=0x5555.
REQ-031 Stall refresh: held rt=3, stall=1, memwb_wr=1 rd=3 data=0x00FF for one cycle then memwb_wr=0, stall held -> InB stays 0x00FF.
REQ-032 Flush vs stall: stall=1 and flush=1 same edge with ex_valid=1, id_wr=1 -> ex_valid=0, ex_wr=0, Oper=0 next cycle.
REQ-033 Immediate suppression: id_use_imm=1, id_imm=0x0007, rt=1, exmem_wr=1 rd=1 data=0xBEEF -> InB=0x0007.
